median3x3_core: RTL and testbench

- Pipelined, parametrised 3x3 window rank filter; successor to the 3-input min/median/max sorter.
- Accepts one 3-pixel window column per valid cycle and holds the last three sorted columns.
- Emits the median, minimum or maximum of the 9-pixel window, selected per window by a mode input. Minimum and maximum give erosion and dilation.
- Sits between the 3-line buffer (column source) and the output pixel stream of the median filter.

---
 rtl/median_pkg.sv | 30 +++
 rtl/sort3_net.sv | 25 ++
 rtl/median3x3_core.sv | 164 ++++++++++++++++
 tb/tb_median3x3_core.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared constants and unsigned rank helpers for the 3x3 window rank filter.
// Helpers work on MAX_WIDTH-bit values; callers zero-extend and truncate.
package median_pkg;

  localparam int unsigned LATENCY   = 2;
  localparam int unsigned MAX_WIDTH = 16;

  localparam logic [1:0] MODE_MEDIAN = 2'd0;
  localparam logic [1:0] MODE_MIN    = 2'd1;
  localparam logic [1:0] MODE_MAX    = 2'd2;

  typedef logic [MAX_WIDTH-1:0] pixT;

  function automatic pixT min2(input pixT a, input pixT b);
    return (a < b) ? a : b;
  endfunction

  function automatic pixT max2(input pixT a, input pixT b);
    return (a < b) ? b : a;
  endfunction

  function automatic pixT min3(input pixT a, input pixT b, input pixT c);
    return min2(min2(a, b), c);
  endfunction

  function automatic pixT max3(input pixT a, input pixT b, input pixT c);
    return max2(max2(a, b), c);
  endfunction

endpackage

// File: rtl/sort3_net.sv
// Combinational three-input sorter: unsigned min, median and max.
module sort3_net #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic [WIDTH-1:0] iC,
  output logic [WIDTH-1:0] oMin,
  output logic [WIDTH-1:0] oMed,
  output logic [WIDTH-1:0] oMax
);

  logic [WIDTH-1:0] lo1, hi1, upper;

  always_comb begin
    lo1   = (iA < iB) ? iA : iB;
    hi1   = (iA < iB) ? iB : iA;
    oMin  = (lo1 < iC) ? lo1 : iC;
    // upper is max(lo1, c); the median is the smaller of it and hi1
    upper = (lo1 < iC) ? iC : lo1;
    oMed  = (upper < hi1) ? upper : hi1;
    oMax  = (upper < hi1) ? hi1 : upper;
  end

endmodule

// File: rtl/median3x3_core.sv
// Pipelined 3x3 window rank filter: median, erosion (min) or dilation (max)
// over the last three sorted columns, result two edges after the completing column.
module median3x3_core
  import median_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  input  logic             iSol,
  input  logic [1:0]       iMode,
  input  logic [WIDTH-1:0] iNumA,
  input  logic [WIDTH-1:0] iNumB,
  input  logic [WIDTH-1:0] iNumC,
  output logic             oValid,
  output logic [WIDTH-1:0] oNum
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : gBadWidth
    $error("median3x3_core: WIDTH out of range");
  end

  // Stage W: sorted column window, index 0 is the newest column
  logic [WIDTH-1:0] colL, colM, colH;
  logic [WIDTH-1:0] winLQ [3];
  logic [WIDTH-1:0] winMQ [3];
  logic [WIDTH-1:0] winHQ [3];
  logic [1:0]       cntQ, cntD;
  logic             wfull;
  logic             fullQ;
  logic [1:0]       modeQ;

  // Stage 2 registers
  logic [WIDTH-1:0] loMaxQ, midMedQ, hiMinQ, allMinQ, allMaxQ;
  logic [WIDTH-1:0] loMaxD, midMedD, hiMinD, allMinD, allMaxD;
  logic             s2ValidQ;
  logic [1:0]       s2ModeQ;

  // Stage 3 select
  logic [WIDTH-1:0] finalMed, selNum;

  logic [WIDTH-1:0] midMin, midMax, finMin, finMax;
  logic             unusedSort;

  sort3_net #(.WIDTH(WIDTH)) colSort (
    .iA   (iNumA),
    .iB   (iNumB),
    .iC   (iNumC),
    .oMin (colL),
    .oMed (colM),
    .oMax (colH)
  );

  always_comb begin
    if (iSol) begin
      cntD = 2'd1;
    end else if (cntQ == 2'd3) begin
      cntD = 2'd3;
    end else begin
      cntD = cntQ + 2'd1;
    end
    wfull = iValid && (cntD == 2'd3);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < 3; i++) begin
        winLQ[i] <= '0;
        winMQ[i] <= '0;
        winHQ[i] <= '0;
      end
      cntQ  <= 2'd0;
      fullQ <= 1'b0;
      modeQ <= MODE_MEDIAN;
    end else begin
      if (iValid) begin
        winLQ[2] <= winLQ[1];
        winMQ[2] <= winMQ[1];
        winHQ[2] <= winHQ[1];
        winLQ[1] <= winLQ[0];
        winMQ[1] <= winMQ[0];
        winHQ[1] <= winHQ[0];
        winLQ[0] <= colL;
        winMQ[0] <= colM;
        winHQ[0] <= colH;
        cntQ     <= cntD;
        modeQ    <= iMode;
      end
      fullQ <= wfull;
    end
  end

  sort3_net #(.WIDTH(WIDTH)) midSort (
    .iA   (winMQ[0]),
    .iB   (winMQ[1]),
    .iC   (winMQ[2]),
    .oMin (midMin),
    .oMed (midMedD),
    .oMax (midMax)
  );

  always_comb begin
    loMaxD  = WIDTH'(max3(pixT'(winLQ[0]), pixT'(winLQ[1]), pixT'(winLQ[2])));
    hiMinD  = WIDTH'(min3(pixT'(winHQ[0]), pixT'(winHQ[1]), pixT'(winHQ[2])));
    allMinD = WIDTH'(min3(pixT'(winLQ[0]), pixT'(winLQ[1]), pixT'(winLQ[2])));
    allMaxD = WIDTH'(max3(pixT'(winHQ[0]), pixT'(winHQ[1]), pixT'(winHQ[2])));
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      loMaxQ   <= '0;
      midMedQ  <= '0;
      hiMinQ   <= '0;
      allMinQ  <= '0;
      allMaxQ  <= '0;
      s2ValidQ <= 1'b0;
      s2ModeQ  <= MODE_MEDIAN;
    end else begin
      s2ValidQ <= fullQ;
      if (fullQ) begin
        loMaxQ  <= loMaxD;
        midMedQ <= midMedD;
        hiMinQ  <= hiMinD;
        allMinQ <= allMinD;
        allMaxQ <= allMaxD;
        s2ModeQ <= modeQ;
      end
    end
  end

  sort3_net #(.WIDTH(WIDTH)) finalSort (
    .iA   (loMaxQ),
    .iB   (midMedQ),
    .iC   (hiMinQ),
    .oMin (finMin),
    .oMed (finalMed),
    .oMax (finMax)
  );

  // Mode 3 is reserved and falls back to the median
  always_comb begin
    case (s2ModeQ)
      MODE_MIN: selNum = allMinQ;
      MODE_MAX: selNum = allMaxQ;
      default:  selNum = finalMed;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oValid <= 1'b0;
      oNum   <= '0;
    end else begin
      oValid <= s2ValidQ;
      if (s2ValidQ) begin
        oNum <= selNum;
      end
    end
  end

  assign unusedSort = ^{midMin, midMax, finMin, finMax};

endmodule

// File: tb/tb_median3x3_core.sv
// Self-checking bench for median3x3_core: WIDTH=8 and WIDTH=12 instances share
// stimulus; a 9-pixel sort model predicts every output cycle.
module tb_median3x3_core;
  import median_pkg::*;

  logic        clk = 1'b0;
  logic        rstN;
  logic        valid, sol;
  logic [1:0]  mode;
  logic [11:0] a, b, c;
  logic        v8, v12;
  logic [7:0]  n8;
  logic [11:0] n12;

  always #5 clk = ~clk;

  median3x3_core #(.WIDTH(8)) dut8 (
    .iClk   (clk),
    .iRst_n (rstN),
    .iValid (valid),
    .iSol   (sol),
    .iMode  (mode),
    .iNumA  (a[7:0]),
    .iNumB  (b[7:0]),
    .iNumC  (c[7:0]),
    .oValid (v8),
    .oNum   (n8)
  );

  median3x3_core #(.WIDTH(12)) dut12 (
    .iClk   (clk),
    .iRst_n (rstN),
    .iValid (valid),
    .iSol   (sol),
    .iMode  (mode),
    .iNumA  (a),
    .iNumB  (b),
    .iNumC  (c),
    .oValid (v12),
    .oNum   (n12)
  );

  localparam int Off = LATENCY + 1;

  int          checks = 0;
  int          errors = 0;
  int          edges  = 0;
  bit          expV   [0:4095];
  logic [11:0] expN8  [0:4095];
  logic [11:0] expN12 [0:4095];
  logic [11:0] win    [0:8];
  int          cnt;
  int          lastIdx;
  logic [11:0] held8, held12;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, want, edges);
    end
  endtask

  // Rank of the 9 raw window pixels after masking to w bits
  function automatic logic [11:0] rankOf(input logic [1:0] md, input int w);
    logic [11:0] s [9];
    logic [11:0] t;
    logic [11:0] mask;
    mask = 12'((1 << w) - 1);
    for (int i = 0; i < 9; i++) s[i] = win[i] & mask;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8 - i; j++)
        if (s[j] > s[j+1]) begin
          t = s[j]; s[j] = s[j+1]; s[j+1] = t;
        end
    case (md)
      2'd1:    return s[0];
      2'd2:    return s[8];
      default: return s[4];
    endcase
  endfunction

  task automatic col(input bit v, input bit s, input logic [1:0] md,
                     input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    int idx;
    @(negedge clk);
    valid = v; sol = s; mode = md; a = x; b = y; c = z;
    if (v) begin
      if (s) cnt = 1;
      else if (cnt < 3) cnt++;
      for (int i = 8; i >= 3; i--) win[i] = win[i-3];
      win[0] = x; win[1] = y; win[2] = z;
      if (cnt == 3) begin
        idx         = edges + Off;
        expV[idx]   = 1'b1;
        expN8[idx]  = rankOf(md, 8);
        expN12[idx] = rankOf(md, 12);
        lastIdx     = idx;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) col(1'b0, 1'b1, 2'd2, 12'hABC, 12'h123, 12'h0F0);
  endtask

  task automatic pin8(input string name, input int want);
    check(name, int'(expN8[lastIdx]), want);
  endtask

  task automatic pin12(input string name, input int want);
    check(name, int'(expN12[lastIdx]), want);
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    rstN  = 1'b0;
    valid = 1'b0;
    cnt   = 0;
    for (int i = 0; i < 9; i++) win[i] = '0;
    for (int i = 1; i <= Off; i++) expV[edges + i] = 1'b0;
    repeat (n) @(negedge clk);
    rstN = 1'b1;
  endtask

  // Standard five-column stream, one mode per column
  task automatic stream(input logic [1:0] m3, input logic [1:0] m4, input logic [1:0] m5);
    col(1'b1, 1'b1, 2'd0, 12'd0, 12'd0, 12'd4);
    col(1'b1, 1'b0, 2'd0, 12'd3, 12'd1, 12'd1);
    col(1'b1, 1'b0, m3, 12'd12, 12'd7, 12'd4);
    col(1'b1, 1'b0, m4, 12'd3, 12'd10, 12'd4);
    col(1'b1, 1'b0, m5, 12'd2, 12'd2, 12'd2);
  endtask

  // Compare process: every cycle, #1 after the rising edge
  initial begin
    held8  = '0;
    held12 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstN) begin
        held8  = '0;
        held12 = '0;
        check("resetValid8", int'(v8), 0);
        check("resetNum8", int'(n8), 0);
        check("resetValid12", int'(v12), 0);
        check("resetNum12", int'(n12), 0);
      end else begin
        if (expV[edges]) begin
          held8  = expN8[edges];
          held12 = expN12[edges];
        end
        check("oValid8", int'(v8), int'(expV[edges]));
        check("oNum8", int'(n8), int'(held8));
        check("oValid12", int'(v12), int'(expV[edges]));
        check("oNum12", int'(n12), int'(held12));
      end
    end
  end

  initial begin
    rstN = 1'b0; valid = 1'b0; sol = 1'b0; mode = 2'd0;
    a = '0; b = '0; c = '0;
    cnt = 0; lastIdx = 0;
    for (int i = 0; i < 9; i++) win[i] = '0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    idle(2);

    // Median, back-to-back
    col(1'b1, 1'b1, 2'd0, 12'd0, 12'd0, 12'd4);
    col(1'b1, 1'b0, 2'd0, 12'd3, 12'd1, 12'd1);
    col(1'b1, 1'b0, 2'd0, 12'd12, 12'd7, 12'd4);  pin8("pinMed1", 3);
    col(1'b1, 1'b0, 2'd0, 12'd3, 12'd10, 12'd4);  pin8("pinMed2", 4);
    col(1'b1, 1'b0, 2'd0, 12'd2, 12'd2, 12'd2);   pin8("pinMed3", 4);
    idle(4);

    stream(2'd1, 2'd1, 2'd1);  pin8("pinMin3", 2);
    idle(1);
    stream(2'd2, 2'd2, 2'd2);  pin8("pinMax3", 12);
    // Mode changes per window, directly back-to-back with the previous stream
    stream(2'd0, 2'd1, 2'd2);
    stream(2'd3, 2'd1, 2'd0);  pin8("pinRsvdTail", 4);
    idle(4);

    // Bubbles between every column; iSol/iMode ignored while idle
    col(1'b1, 1'b1, 2'd0, 12'd0, 12'd0, 12'd4);   idle(1);
    col(1'b1, 1'b0, 2'd0, 12'd3, 12'd1, 12'd1);   idle(1);
    col(1'b1, 1'b0, 2'd0, 12'd12, 12'd7, 12'd4);  idle(1);
    col(1'b1, 1'b0, 2'd0, 12'd3, 12'd10, 12'd4);  idle(1);
    col(1'b1, 1'b0, 2'd0, 12'd2, 12'd2, 12'd2);   pin8("pinBubble", 4);
    idle(4);

    // iSol restarts a full window
    col(1'b1, 1'b1, 2'd0, 12'd0, 12'd0, 12'd4);
    col(1'b1, 1'b0, 2'd0, 12'd3, 12'd1, 12'd1);
    col(1'b1, 1'b0, 2'd0, 12'd12, 12'd7, 12'd4);
    col(1'b1, 1'b1, 2'd0, 12'd3, 12'd10, 12'd4);
    col(1'b1, 1'b0, 2'd0, 12'd2, 12'd2, 12'd2);
    col(1'b1, 1'b0, 2'd0, 12'd5, 12'd5, 12'd5);   pin8("pinSol", 4);
    idle(4);

    // Reset with a result in flight, then reset between columns 2 and 3
    stream(2'd0, 2'd0, 2'd0);
    doReset(2);
    col(1'b1, 1'b1, 2'd0, 12'd0, 12'd0, 12'd4);
    col(1'b1, 1'b0, 2'd0, 12'd3, 12'd1, 12'd1);
    doReset(3);
    col(1'b1, 1'b0, 2'd0, 12'd12, 12'd7, 12'd4);
    col(1'b1, 1'b0, 2'd0, 12'd3, 12'd10, 12'd4);
    col(1'b1, 1'b0, 2'd0, 12'd2, 12'd2, 12'd2);   pin8("pinPostReset", 4);
    idle(4);

    // Wide pixels: one zero among 4095s, then an all-equal window
    col(1'b1, 1'b1, 2'd0, 12'd4095, 12'd4095, 12'd4095);
    col(1'b1, 1'b0, 2'd0, 12'd4095, 12'd0, 12'd4095);
    col(1'b1, 1'b0, 2'd0, 12'd4095, 12'd4095, 12'd4095);
    pin12("pinWideMed", 4095);  pin8("pinNarrowMed", 255);
    col(1'b1, 1'b0, 2'd1, 12'd4095, 12'd4095, 12'd4095);  pin12("pinWideMin", 0);
    col(1'b1, 1'b0, 2'd2, 12'd4095, 12'd4095, 12'd4095);  pin12("pinWideMax", 4095);
    col(1'b1, 1'b1, 2'd0, 12'd2748, 12'd2748, 12'd2748);
    col(1'b1, 1'b0, 2'd0, 12'd2748, 12'd2748, 12'd2748);
    col(1'b1, 1'b0, 2'd0, 12'd2748, 12'd2748, 12'd2748);  pin12("pinEqMed", 2748);
    col(1'b1, 1'b0, 2'd1, 12'd2748, 12'd2748, 12'd2748);  pin12("pinEqMin", 2748);
    col(1'b1, 1'b0, 2'd2, 12'd2748, 12'd2748, 12'd2748);  pin8("pinEqMax8", 188);
    idle(4);

    // Mixed traffic checked purely against the model
    for (int i = 0; i < 60; i++) begin
      col(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
          2'($urandom_range(0, 3)), 12'($urandom), 12'($urandom), 12'($urandom));
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
